// File: rtl/bsnn_pkg.sv
// Shared definitions for the BSNN spike readout: FSM state encoding,
// derived-size helpers and the saturating accumulator add.
package bsnn_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_ARGMAX = 2'd1,
        ST_OUTPUT = 2'd2
    } readout_state_e;

    // Neurons per class population.
    function automatic int group_size(input int n_neurons, input int n_classes);
        return n_neurons / n_classes;
    endfunction

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // a + b clamped to max_val; a 33-bit sum avoids wrap before the clamp.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/bsnn_popcount.sv
// Combinational population count of one class group of spikes.
module bsnn_popcount #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]           bits,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    localparam int PC_W = $clog2(WIDTH + 1);

    // Sum the set bits of the group.
    always_comb begin
        count = {PC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            count = count + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/bsnn_spike_readout.sv
// Spike-count readout: accumulates per-class spike counts over a window of
// NUM_STEPS accepted vectors, runs a sequential argmax (lowest index wins
// ties) and offers the winning class on a valid/ready handshake.
module bsnn_spike_readout
    import bsnn_pkg::*;
#(
    parameter int N_NEURONS = 256,
    parameter int N_CLASSES = 8,
    parameter int NUM_STEPS = 16,
    parameter int CNT_W     = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_NEURONS-1:0]               spike_vector,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [idx_width(N_CLASSES)-1:0]    class_id,
    output logic [CNT_W-1:0]                   max_count,
    output logic                               busy
);

    localparam int          GROUP   = group_size(N_NEURONS, N_CLASSES);
    localparam int          IDX_W   = idx_width(N_CLASSES);
    localparam int          STEP_W  = idx_width(NUM_STEPS);
    localparam int          PC_W    = $clog2(GROUP + 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [PC_W-1:0]  pc_s [N_CLASSES];

    readout_state_e   state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] cnt_q [N_CLASSES];
    logic [CNT_W-1:0] cnt_d [N_CLASSES];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] class_id_q, class_id_d;
    logic [CNT_W-1:0] max_count_q, max_count_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    for (genvar g = 0; g < N_CLASSES; g++) begin : g_pc
        bsnn_popcount #(.WIDTH(GROUP)) u_pc (
            .bits  (spike_vector[g*GROUP +: GROUP]),
            .count (pc_s[g])
        );
    end

    // Next-state logic: accumulate, argmax scan, and output handshake.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_cnt_d  = best_cnt_q;
        out_valid_d = out_valid_q;
        class_id_d  = class_id_q;
        max_count_d = max_count_q;
        for (int c = 0; c < N_CLASSES; c++) begin
            cnt_d[c] = cnt_q[c];
        end

        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    for (int c = 0; c < N_CLASSES; c++) begin
                        cnt_d[c] = CNT_W'(sat_add(32'(cnt_q[c]), 32'(pc_s[c]), CNT_MAX));
                    end
                    step_d = step_q + STEP_W'(1);
                    if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                        state_d    = ST_ARGMAX;
                        idx_d      = {IDX_W{1'b0}};
                        best_idx_d = {IDX_W{1'b0}};
                        best_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ARGMAX: begin
                // Index 0 always seeds the best; later entries need strict >.
                if ((idx_q == {IDX_W{1'b0}}) || (cnt_q[idx_q] > best_cnt_q)) begin
                    best_idx_d = idx_q;
                    best_cnt_d = cnt_q[idx_q];
                end else begin
                    best_idx_d = best_idx_q;
                end
                if (idx_q == IDX_W'(N_CLASSES - 1)) begin
                    state_d     = ST_OUTPUT;
                    out_valid_d = 1'b1;
                    class_id_d  = best_idx_d;
                    max_count_d = best_cnt_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                    step_d      = {STEP_W{1'b0}};
                    for (int c = 0; c < N_CLASSES; c++) begin
                        cnt_d[c] = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                out_valid_d = 1'b0;
            end
        endcase

        // Status flags are registered from the next state so they never
        // depend combinationally on an input.
        in_ready_d = (state_d == ST_ACCUM);
        busy_d     = !((state_d == ST_ACCUM) && (step_d == {STEP_W{1'b0}}));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_ACCUM;
            step_q      <= {STEP_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            best_idx_q  <= {IDX_W{1'b0}};
            best_cnt_q  <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            class_id_q  <= {IDX_W{1'b0}};
            max_count_q <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt_q[c] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_cnt_q  <= best_cnt_d;
            out_valid_q <= out_valid_d;
            class_id_q  <= class_id_d;
            max_count_q <= max_count_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign class_id  = class_id_q;
    assign max_count = max_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bsnn_spike_readout.sv
// Directed bench for bsnn_spike_readout: default instance plus a CNT_W=6
// instance sharing the same stimulus for the saturation case.
module tb_bsnn_spike_readout;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [255:0] spike_vector;
    logic         out_ready;

    logic         in_ready;
    logic         out_valid;
    logic [2:0]   class_id;
    logic [9:0]   max_count;
    logic         busy;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [2:0]   s_class_id;
    logic [5:0]   s_max_count;
    logic         s_busy;

    int chk_cnt;
    int err_cnt;
    int lat;

    logic [255:0] v;

    bsnn_spike_readout dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .spike_vector (spike_vector),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .class_id     (class_id),
        .max_count    (max_count),
        .busy         (busy)
    );

    bsnn_spike_readout #(.CNT_W(6)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (s_in_ready),
        .spike_vector (spike_vector),
        .out_valid    (s_out_valid),
        .out_ready    (out_ready),
        .class_id     (s_class_id),
        .max_count    (s_max_count),
        .busy         (s_busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present n copies of vec on consecutive cycles, then drop in_valid.
    task automatic feed(input logic [255:0] vec, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid     = 1'b1;
            spike_vector = vec;
            @(posedge clk);
        end
        #1;
        in_valid     = 1'b0;
        spike_vector = '0;
    endtask

    // Count edges from the last accept until out_valid rises (bounded).
    task automatic wait_out(input string tag);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd8);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    // Single-cycle out_ready pulse, then confirm return to ACCUM.
    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_val({tag, "_ov_clear"}, 32'(out_valid), 32'd0);
        check_val({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        chk_cnt      = 0;
        err_cnt      = 0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        spike_vector = '0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_class_id", 32'(class_id), 32'd0);
        check_val("rst_max_count", 32'(max_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Class 3 dominant: 32 bits x 16 steps = 512.
        v = '0;
        v[127:96] = '1;
        feed(v, 1);
        check_val("busy_after_first", 32'(busy), 32'd1);
        feed(v, 15);
        wait_out("c3");
        check_val("c3_class", 32'(class_id), 32'd3);
        check_val("c3_count", 32'(max_count), 32'd512);
        take("c3");

        // All zero: class 0 wins with count 0.
        v = '0;
        feed(v, 16);
        wait_out("zero");
        check_val("zero_class", 32'(class_id), 32'd0);
        check_val("zero_count", 32'(max_count), 32'd0);
        take("zero");

        // Tie between classes 2 and 5: lower index wins, 8 x 16 = 128.
        v = '0;
        v[71:64]   = '1;
        v[167:160] = '1;
        feed(v, 16);
        wait_out("tie");
        check_val("tie_class", 32'(class_id), 32'd2);
        check_val("tie_count", 32'(max_count), 32'd128);
        take("tie");

        // Backpressure with random traffic on the input side.
        v = '0;
        v[127:96] = '1;
        feed(v, 16);
        wait_out("bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int w = 0; w < 8; w++) begin
                spike_vector[w*32 +: 32] = $urandom();
            end
            @(posedge clk);
            #1;
            check_val("bp_hold_valid", 32'(out_valid), 32'd1);
            check_val("bp_hold_class", 32'(class_id), 32'd3);
            check_val("bp_hold_count", 32'(max_count), 32'd512);
            check_val("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        // in_valid stays high with random data through the handoff cycle.
        take("bp");
        check_val("bp_class_kept", 32'(class_id), 32'd3);
        check_val("bp_count_kept", 32'(max_count), 32'd512);
        v = '0;
        v[255] = 1'b1;
        feed(v, 16);
        wait_out("b255");
        check_val("b255_class", 32'(class_id), 32'd7);
        check_val("b255_count", 32'(max_count), 32'd16);
        take("b255");

        // Mid-window reset discards partial class-1 counts.
        v = '0;
        v[63:32] = '1;
        feed(v, 7);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_val("mid_rst_class", 32'(class_id), 32'd0);
        v = '0;
        v[0] = 1'b1;
        feed(v, 16);
        wait_out("mid");
        check_val("mid_class", 32'(class_id), 32'd0);
        check_val("mid_count", 32'(max_count), 32'd16);
        take("mid");

        // Saturation: class 4 all ones, 512 raw; 6-bit counters clamp at 63.
        v = '0;
        v[159:128] = '1;
        feed(v, 16);
        wait_out("sat");
        check_val("sat_wide_class", 32'(class_id), 32'd4);
        check_val("sat_wide_count", 32'(max_count), 32'd512);
        check_val("sat_valid", 32'(s_out_valid), 32'd1);
        check_val("sat_class", 32'(s_class_id), 32'd4);
        check_val("sat_count", 32'(s_max_count), 32'd63);
        take("sat");

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
